sdm_mash: RTL and testbench

Third-order MASH 1-1-1 sigma-delta modulator that drives the integer divider of a fractional-N PLL. It runs on the reference clock (38.4 MHz nominal). Each cycle it adds a dithered offset, ranging −3..+4, to the integer divide value N so that the long-run average divide ratio is N + din/2^w. It also exposes the final-stage quantization residue for debug.

---
 rtl/sdm_mash.sv | 81 ++++++++
 tb/tb_sdm_mash.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sdm_mash.sv
// Third-order MASH 1-1-1 sigma-delta modulator for a fractional-N divider.
// Each cycle div_ctrl = N + y (mod 64), y in -3..+4, so the mean ratio is N + din/2^w.

module sdm_acc_stage #(
   parameter int w = 16
) (
   input  logic [w-1:0] acc,
   input  logic [w-1:0] x,
   output logic [w-1:0] s,
   output logic         c
);
   always_comb {c, s} = {1'b0, acc} + {1'b0, x};
endmodule

module sdm_mash #(
   parameter int w = 16
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [w-1:0]        din,
   input  logic [5:0]          N,
   output logic signed [5:0]   div_ctrl,
   output logic [w-1:0]        sdm_qn
);
   localparam int STAGES = 3;

   logic [STAGES-1:0][w-1:0] acc_q;
   logic [STAGES-1:0][w-1:0] stg_in;
   logic [STAGES-1:0][w-1:0] stg_s;
   logic [STAGES-1:0]        stg_c;
   logic                     d2, d3a, d3b;
   logic signed [3:0]        y;
   logic [5:0]               div_nxt;

   // Each stage integrates the residue of the stage before it.
   genvar g;
   generate
      for (g = 0; g < STAGES; g++) begin : g_stage
         if (g == 0) begin : g_first
            assign stg_in[g] = din;
         end else begin : g_chain
            assign stg_in[g] = stg_s[g-1];
         end
         sdm_acc_stage #(.w(w)) u_stage (
            .acc (acc_q[g]),
            .x   (stg_in[g]),
            .s   (stg_s[g]),
            .c   (stg_c[g])
         );
      end
   endgenerate

   // Noise-cancellation network: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3
   always_comb begin
      y = $signed({3'b000, stg_c[0]})
        + $signed({3'b000, stg_c[1]})
        - $signed({3'b000, d2})
        + $signed({3'b000, stg_c[2]})
        - $signed({2'b00, d3a, 1'b0})
        + $signed({3'b000, d3b});
      div_nxt = N + {{2{y[3]}}, y};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc_q    <= '0;
         d2       <= 1'b0;
         d3a      <= 1'b0;
         d3b      <= 1'b0;
         div_ctrl <= '0;
      end else begin
         acc_q    <= stg_s;
         d2       <= stg_c[1];
         d3a      <= stg_c[2];
         d3b      <= d3a;
         div_ctrl <= $signed(div_nxt);
      end
   end

   assign sdm_qn = acc_q[STAGES-1];
endmodule

// File: tb/tb_sdm_mash.sv
// Directed bench for sdm_mash: reset, zero/half fraction, long-run mean,
// mid-run reset and a fraction change, all against hand-computed values.

module tb_sdm_mash;
   localparam int W = 16;

   logic               clk = 1'b0;
   logic               rstn;
   logic [W-1:0]       din;
   logic [5:0]         N;
   logic signed [5:0]  div_ctrl;
   logic [W-1:0]       sdm_qn;
   logic [5:0]         dcu;

   int n_chk = 0;
   int n_err = 0;

   // Hand-derived first 7 outputs after release with din=39425, N=30.
   int exp_div [7] = '{30, 32, 30, 30, 31, 30, 32};
   int exp_qn  [7] = '{39425, 26628, 1034, 2068, 3619, 45112, 34900};
   // din=32768 repeats with period 4.
   int half_div [4] = '{30, 32, 29, 31};
   int half_qn  [4] = '{32768, 0, 0, 0};

   sdm_mash #(.w(W)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .din      (din),
      .N        (N),
      .div_ctrl (div_ctrl),
      .sdm_qn   (sdm_qn)
   );

   assign dcu = div_ctrl;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Signed offset of div_ctrl from N, folded out of the mod-64 wrap.
   function automatic int delta_of(input logic [5:0] v, input logic [5:0] n);
      int d;
      d = (int'(v) - int'(n) + 64) % 64;
      if (d >= 32) d -= 64;
      return d;
   endfunction

   initial begin
      int sum;
      int d;
      bit in_tol;

      rstn = 1'b0;
      din  = 16'd39425;
      N    = 6'd30;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("rst_div", dcu, 0);
         chk("rst_qn", sdm_qn, 0);
      end

      din  = '0;
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("zero_div", dcu, 30);
         chk("zero_qn", sdm_qn, 0);
      end

      rstn = 1'b0;
      cyc();
      din  = 16'd32768;
      rstn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         chk("half_div", dcu, half_div[i % 4]);
         chk("half_qn", sdm_qn, half_qn[i % 4]);
      end

      rstn = 1'b0;
      cyc();
      din  = 16'd39425;
      rstn = 1'b1;
      sum  = 0;
      for (int i = 0; i < 10000; i++) begin
         cyc();
         if (i < 7) begin
            chk("run_div", dcu, exp_div[i]);
            chk("run_qn", sdm_qn, exp_qn[i]);
         end
         d = delta_of(dcu, N);
         chk("run_range", (d >= -3 && d <= 4) ? 1 : 0, 1);
         sum += d;
      end
      // 10000 * 0.6016 = 6016, tolerance 0.001 -> +/-10
      in_tol = (sum >= 6006 && sum <= 6026);
      chk("mean_x1e4", in_tol ? 32'd6016 : 32'(sum), 32'd6016);

      rstn = 1'b0;
      cyc();
      chk("mid_rst_div", dcu, 0);
      chk("mid_rst_qn", sdm_qn, 0);
      rstn = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc();
         chk("rerun_div", dcu, exp_div[i]);
         chk("rerun_qn", sdm_qn, exp_qn[i]);
      end

      for (int i = 0; i < 5; i++) cyc();
      din = '0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("chg_noX", $isunknown(div_ctrl) ? 1 : 0, 0);
         d = delta_of(dcu, N);
         chk("chg_range", (d >= -3 && d <= 4) ? 1 : 0, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
